// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the I/D memory-port arbiter: FSM states, owner ids
// and default bus widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between the I and D requesters; purely combinational.
// On a tie the side not granted last wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_last_grant,
  output logic o_any,
  output logic o_winner
);

  always_comb begin
    o_any = i_req_i | i_req_d;
    if (i_req_i && i_req_d) begin
      o_winner = ~i_last_grant;
    end else if (i_req_d) begin
      o_winner = OWNER_D;
    end else begin
      o_winner = OWNER_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// One-line-at-a-time arbiter of the backing memory port between I and D refills.
// Grant in IDLE, then ISSUE (held until mem_is_ready), WAIT for completion, one-cycle RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_is_input_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_is_output_valid,
  output logic [LINE_W-1:0] i_dout,
  input  logic              d_is_input_valid,
  input  logic              d_mem_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_din,
  output logic              d_grant,
  output logic              d_is_output_valid,
  output logic [LINE_W-1:0] d_dout,
  output logic              mem_is_input_valid,
  input  logic              mem_is_ready,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_din,
  input  logic              mem_is_output_valid,
  input  logic [LINE_W-1:0] mem_dout,
  output logic [CNT_W-1:0]  grant_count_i,
  output logic [CNT_W-1:0]  grant_count_d
);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic                r_rw;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_din;
  logic [LINE_W-1:0]   r_i_dout;
  logic [LINE_W-1:0]   r_d_dout;
  logic [CNT_W-1:0]    r_cnt_i;
  logic [CNT_W-1:0]    r_cnt_d;
  logic                w_any;
  logic                w_winner;
  logic                w_grant_fire;

  rr_arbiter2 u_rr (
    .i_req_i      (i_is_input_valid),
    .i_req_d      (d_is_input_valid),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  // A grant shown while reset is high would never be latched, so suppress it.
  assign w_grant_fire = (r_state == ST_IDLE) && w_any && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    i_grant            = 1'b0;
    d_grant            = 1'b0;
    mem_is_input_valid = 1'b0;
    i_is_output_valid  = 1'b0;
    d_is_output_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_fire) begin
          w_next_state = ST_ISSUE;
          i_grant      = (w_winner == OWNER_I);
          d_grant      = (w_winner == OWNER_D);
        end
      end
      ST_ISSUE: begin
        mem_is_input_valid = 1'b1;
        if (mem_is_ready) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_is_output_valid) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        i_is_output_valid = (r_owner == OWNER_I);
        d_is_output_valid = (r_owner == OWNER_D);
        w_next_state      = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWNER_I;
      r_rw         <= 1'b0;
      r_last_grant <= OWNER_I;
      r_addr       <= '0;
      r_din        <= '0;
      r_i_dout     <= '0;
      r_d_dout     <= '0;
      r_cnt_i      <= '0;
      r_cnt_d      <= '0;
    end else begin
      if (w_grant_fire) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        if (w_winner == OWNER_D) begin
          r_rw   <= d_mem_rw;
          r_addr <= d_addr;
          r_din  <= d_din;
          if (r_cnt_d != '1) r_cnt_d <= r_cnt_d + CNT_W'(1);
        end else begin
          r_rw   <= 1'b0;
          r_addr <= i_addr;
          r_din  <= '0;
          if (r_cnt_i != '1) r_cnt_i <= r_cnt_i + CNT_W'(1);
        end
      end
      // Write completions only acknowledge; d_dout keeps the last read line.
      if (r_state == ST_WAIT && mem_is_output_valid) begin
        if (r_owner == OWNER_I) begin
          r_i_dout <= mem_dout;
        end else if (!r_rw) begin
          r_d_dout <= mem_dout;
        end
      end
    end
  end

  assign mem_rw        = r_rw & (r_owner == OWNER_D);
  assign mem_addr      = r_addr;
  assign mem_din       = r_din;
  assign i_dout        = r_i_dout;
  assign d_dout        = r_d_dout;
  assign grant_count_i = r_cnt_i;
  assign grant_count_d = r_cnt_d;

endmodule
